// File: rtl/jtoutrun_fetch_pkg.sv
// Shared definitions for the two-slot ROM fetch controller: SDRAM bank
// geometry, fetch FSM encoding and a saturating counter helper.
package jtoutrun_fetch_pkg;

    localparam int SDRAM_AW = 22;
    localparam int SDRAM_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/jtoutrun_fetch_cache.sv
// Single-entry read cache for one fetch slot. Holds the last fetched word
// with its slot address and a valid bit; hit/ok are combinational from the
// registered entry. An invalidate in the same cycle as a fill wins.
module jtoutrun_fetch_cache
    import jtoutrun_fetch_pkg::*;
#(
    parameter int AW = 17,
    parameter int DW = 16
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          clr,
    input  logic          wr,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          hit,
    output logic          ok,
    output logic [DW-1:0] dout
);

    logic          valid;
    logic [AW-1:0] cached_addr;
    logic [DW-1:0] cached_data;

    // Cache entry: fill on wr, invalidate on clr (clr has priority on valid).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid       <= 1'b0;
            cached_addr <= '0;
            cached_data <= '0;
        end else begin
            if (wr) begin
                cached_addr <= wr_addr;
                cached_data <= wr_data;
            end
            if (clr)
                valid <= 1'b0;
            else if (wr)
                valid <= 1'b1;
        end
    end

    assign hit  = valid && (cached_addr == addr);
    assign ok   = cs && hit;
    assign dout = cached_data;

endmodule

// File: rtl/jtoutrun_rom_2slot_fetch.sv
// Two-client ROM read controller for one SDRAM bank. Each slot caches its
// last fetched word; misses are arbitrated round-robin and served as one
// SDRAM burst (1 word for 16-bit slots, 2 words low-first for 32-bit slots).
// Optional build macro JTOUTRUN_FETCH_STATS_EN adds per-slot hit/miss
// counters sampled on the rising edge of each chip select.
module jtoutrun_rom_2slot_fetch
    import jtoutrun_fetch_pkg::*;
#(
    parameter int               SLOT0_AW     = 17,
    parameter int               SLOT0_DW     = 16,
    parameter int               SLOT1_AW     = 17,
    parameter int               SLOT1_DW     = 16,
    parameter logic [SDRAM_AW-1:0] SLOT1_OFFSET = 22'h0
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                slot0_cs,
    input  logic [SLOT0_AW-1:0] slot0_addr,
    input  logic                slot0_clr,
    output logic                slot0_ok,
    output logic [SLOT0_DW-1:0] slot0_dout,
    input  logic                slot1_cs,
    input  logic [SLOT1_AW-1:0] slot1_addr,
    input  logic                slot1_clr,
    output logic                slot1_ok,
    output logic [SLOT1_DW-1:0] slot1_dout,
    output logic                sdram_req,
    output logic [SDRAM_AW-1:0] sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_dst,
    input  logic                data_rdy,
    input  logic [SDRAM_DW-1:0] data_read
`ifdef JTOUTRUN_FETCH_STATS_EN
    ,
    output logic [15:0]         hit_cnt0,
    output logic [15:0]         miss_cnt0,
    output logic [15:0]         hit_cnt1,
    output logic [15:0]         miss_cnt1
`endif
);

    fetch_state_t          st, st_nxt;
    logic                  sel;        // slot owning the fetch in flight
    logic                  last_sel;   // slot granted most recently
    logic [SLOT0_AW-1:0]   lat_addr0;
    logic [SLOT1_AW-1:0]   lat_addr1;
    logic [31:0]           asm_r, asm_nxt;
    logic                  hit0, hit1, cand0, cand1, grant, start;
    logic                  wr0, wr1;
    logic [SDRAM_AW-1:0]   map0, map1;

    // Slot address to 16-bit SDRAM word address; wraps modulo 2^22.
    always_comb begin
        map0 = SDRAM_AW'(slot0_addr);
        if (SLOT0_DW == 32) map0 = map0 << 1;
        map1 = SDRAM_AW'(slot1_addr);
        if (SLOT1_DW == 32) map1 = map1 << 1;
        map1 = map1 + SLOT1_OFFSET;
    end

    // Miss candidates and round-robin grant favouring the slot not served last.
    always_comb begin
        cand0   = slot0_cs && !hit0;
        cand1   = slot1_cs && !hit1;
        grant   = (cand0 && cand1) ? ~last_sel : cand1;
        start   = (st == ST_IDLE) && (cand0 || cand1);
        asm_nxt = data_dst ? {data_read, asm_r[31:16]} : asm_r;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= ST_IDLE;
        else        st <= st_nxt;
    end

    // FSM next state.
    always_comb begin
        st_nxt = st;
        case (st)
            ST_IDLE: if (cand0 || cand1) st_nxt = ST_REQ;
            ST_REQ:  if (sdram_ack)      st_nxt = ST_WAIT;
            ST_WAIT: if (data_rdy)       st_nxt = ST_IDLE;
            default:                     st_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: bank request and cache fill strobes.
    always_comb begin
        sdram_req = (st == ST_REQ);
        wr0       = (st == ST_WAIT) && data_rdy && !sel;
        wr1       = (st == ST_WAIT) && data_rdy &&  sel;
    end

    // Grant latch, SDRAM address and burst assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel        <= 1'b0;
            last_sel   <= 1'b0;
            sdram_addr <= '0;
            lat_addr0  <= '0;
            lat_addr1  <= '0;
            asm_r      <= '0;
        end else begin
            if (start) begin
                sel        <= grant;
                last_sel   <= grant;
                sdram_addr <= grant ? map1 : map0;
                lat_addr0  <= slot0_addr;
                lat_addr1  <= slot1_addr;
            end
            if (st == ST_WAIT && data_dst)
                asm_r <= asm_nxt;
        end
    end

    jtoutrun_fetch_cache #(.AW(SLOT0_AW), .DW(SLOT0_DW)) u_cache0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .cs      (slot0_cs),
        .addr    (slot0_addr),
        .clr     (slot0_clr),
        .wr      (wr0),
        .wr_addr (lat_addr0),
        .wr_data (asm_nxt[31 -: SLOT0_DW]),
        .hit     (hit0),
        .ok      (slot0_ok),
        .dout    (slot0_dout)
    );

    jtoutrun_fetch_cache #(.AW(SLOT1_AW), .DW(SLOT1_DW)) u_cache1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .cs      (slot1_cs),
        .addr    (slot1_addr),
        .clr     (slot1_clr),
        .wr      (wr1),
        .wr_addr (lat_addr1),
        .wr_data (asm_nxt[31 -: SLOT1_DW]),
        .hit     (hit1),
        .ok      (slot1_ok),
        .dout    (slot1_dout)
    );

`ifdef JTOUTRUN_FETCH_STATS_EN
    logic cs0_q, cs1_q;

    // Hit/miss statistics on each rising edge of a slot chip select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs0_q     <= 1'b0;
            cs1_q     <= 1'b0;
            hit_cnt0  <= '0;
            miss_cnt0 <= '0;
            hit_cnt1  <= '0;
            miss_cnt1 <= '0;
        end else begin
            cs0_q <= slot0_cs;
            cs1_q <= slot1_cs;
            if (slot0_cs && !cs0_q) begin
                if (hit0) hit_cnt0  <= sat_inc(hit_cnt0);
                else      miss_cnt0 <= sat_inc(miss_cnt0);
            end
            if (slot1_cs && !cs1_q) begin
                if (hit1) hit_cnt1  <= sat_inc(hit_cnt1);
                else      miss_cnt1 <= sat_inc(miss_cnt1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_jtoutrun_rom_2slot_fetch.sv
// Scoreboard bench for jtoutrun_rom_2slot_fetch: stimulus pushes expected
// SDRAM requests and slot ok events; a negedge monitor pops and compares.
module tb_jtoutrun_rom_2slot_fetch;

    localparam int T_REQ = 0;
    localparam int T_OK0 = 1;
    localparam int T_OK1 = 2;

    typedef struct {
        int          tag;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        slot0_cs = 1'b0, slot0_clr = 1'b0, slot0_ok;
    logic [16:0] slot0_addr = '0;
    logic [15:0] slot0_dout;
    logic        slot1_cs = 1'b0, slot1_clr = 1'b0, slot1_ok;
    logic [16:0] slot1_addr = '0;
    logic [31:0] slot1_dout;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack = 1'b0, data_dst = 1'b0, data_rdy = 1'b0;
    logic [15:0] data_read = '0;
`ifdef JTOUTRUN_FETCH_STATS_EN
    logic [15:0] hit_cnt0, miss_cnt0, hit_cnt1, miss_cnt1;
`endif

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   req_count = 0;
    int   rc;
    logic req_q = 1'b0, ok0_q = 1'b0, ok1_q = 1'b0;

    jtoutrun_rom_2slot_fetch #(
        .SLOT0_AW(17), .SLOT0_DW(16),
        .SLOT1_AW(17), .SLOT1_DW(32),
        .SLOT1_OFFSET(22'h080000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .slot0_cs   (slot0_cs),
        .slot0_addr (slot0_addr),
        .slot0_clr  (slot0_clr),
        .slot0_ok   (slot0_ok),
        .slot0_dout (slot0_dout),
        .slot1_cs   (slot1_cs),
        .slot1_addr (slot1_addr),
        .slot1_clr  (slot1_clr),
        .slot1_ok   (slot1_ok),
        .slot1_dout (slot1_dout),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .data_dst   (data_dst),
        .data_rdy   (data_rdy),
        .data_read  (data_read)
`ifdef JTOUTRUN_FETCH_STATS_EN
        ,
        .hit_cnt0   (hit_cnt0),
        .miss_cnt0  (miss_cnt0),
        .hit_cnt1   (hit_cnt1),
        .miss_cnt1  (miss_cnt1)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    function automatic void push(input int tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sbq.push_back(e);
    endfunction

    function automatic void pop_check(input int tag, input logic [31:0] act);
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event tag=%0d actual=%h required=none", tag, act);
            return;
        end
        e = sbq.pop_front();
        if (e.tag != tag || e.val !== act) begin
            errors++;
            $display("FAIL scoreboard tag=%0d actual=%h required tag=%0d value=%h",
                     tag, act, e.tag, e.val);
        end
    endfunction

    // Monitor: every new request and every rising ok is a DUT event.
    always @(negedge clk) begin
        if (sdram_req && !req_q) begin
            req_count <= req_count + 1;
            pop_check(T_REQ, {10'd0, sdram_addr});
        end
        if (slot0_ok && !ok0_q) pop_check(T_OK0, {16'd0, slot0_dout});
        if (slot1_ok && !ok1_q) pop_check(T_OK1, slot1_dout);
        req_q <= sdram_req;
        ok0_q <= slot0_ok;
        ok1_q <= slot1_ok;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!sdram_req && n < 200) begin
            tick();
            n++;
        end
        if (!sdram_req) begin
            checks++;
            errors++;
            $display("FAIL req_timeout actual=0 required=1");
        end
    endtask

    task automatic do_ack(input int dly);
        repeat (dly) tick();
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
    endtask

    task automatic send(input int n, input logic [15:0] w0, input logic [15:0] w1, input bit clr0);
        tick();
        for (int k = 0; k < n; k++) begin
            data_dst  = 1'b1;
            data_read = (k == 0) ? w0 : w1;
            data_rdy  = (k == n - 1);
            slot0_clr = clr0 && (k == n - 1);
            tick();
        end
        data_dst  = 1'b0;
        data_rdy  = 1'b0;
        slot0_clr = 1'b0;
        data_read = '0;
    endtask

    task automatic serve(input int dly, input int n, input logic [15:0] w0, input logic [15:0] w1);
        wait_req();
        do_ack(dly);
        send(n, w0, w1, 1'b0);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_req",   sdram_req,  0);
        check("rst_addr",  sdram_addr, 0);
        check("rst_ok0",   slot0_ok,   0);
        check("rst_ok1",   slot1_ok,   0);
        check("rst_dout0", slot0_dout, 0);
        check("rst_dout1", slot1_dout, 0);
        rst_n = 1'b1;
        tick();

        // 1: slot0 16-bit miss, then a repeat read that must hit
        push(T_REQ, 32'h000123);
        push(T_OK0, 32'hBEEF);
        slot0_addr = 17'h123;
        slot0_cs   = 1'b1;
        serve(4, 1, 16'hBEEF, 16'h0);
        tick(); tick();
        check("t1_ok0", slot0_ok, 1);
        rc = req_count;
        slot0_cs = 1'b0;
        tick();
        check("t1_ok0_cs_low", slot0_ok, 0);
        check("t1_dout_hold",  slot0_dout, 32'hBEEF);
        push(T_OK0, 32'hBEEF);
        slot0_cs = 1'b1;
        tick(); tick();
        check("t1_hit_no_req", req_count, rc);
        slot0_cs = 1'b0;
        tick();

        // 2: slot1 32-bit with offset, low word first
        push(T_REQ, 32'h080020);
        push(T_OK1, 32'h22221111);
        slot1_addr = 17'h10;
        slot1_cs   = 1'b1;
        serve(2, 2, 16'h1111, 16'h2222);
        tick(); tick();
        slot1_cs = 1'b0;
        tick();

        // 3: slot0 served last, then both miss together -> slot1 first
        push(T_REQ, 32'h000040);
        push(T_OK0, 32'h4040);
        slot0_addr = 17'h40;
        slot0_cs   = 1'b1;
        serve(1, 1, 16'h4040, 16'h0);
        tick(); tick();
        rc = req_count;
        push(T_REQ, 32'h080040);
        push(T_OK1, 32'hB2B2A1A1);
        push(T_REQ, 32'h000041);
        push(T_OK0, 32'h4141);
        slot0_addr = 17'h41;
        slot1_addr = 17'h20;
        slot1_cs   = 1'b1;
        serve(1, 2, 16'hA1A1, 16'hB2B2);
        serve(1, 1, 16'h4141, 16'h0);
        tick(); tick();
        check("t3_two_reqs", req_count, rc + 2);
        slot1_cs = 1'b0;
        tick();

        // 4: address changes while waiting for data
        push(T_REQ, 32'h000005);
        slot0_addr = 17'h5;
        wait_req();
        do_ack(1);
        slot0_addr = 17'h6;
        push(T_REQ, 32'h000006);
        push(T_OK0, 32'h0606);
        send(1, 16'h0505, 16'h0, 1'b0);
        check("t4_ok0_stale",   slot0_ok,   0);
        check("t4_fill_latched", slot0_dout, 32'h0505);
        serve(1, 1, 16'h0606, 16'h0);
        tick(); tick();

        // 5: clear coincident with fill -> invalid, refetch
        push(T_REQ, 32'h000007);
        slot0_addr = 17'h7;
        wait_req();
        do_ack(1);
        push(T_REQ, 32'h000007);
        push(T_OK0, 32'h0777);
        send(1, 16'h0707, 16'h0, 1'b1);
        check("t5_clr_wins", slot0_ok, 0);
        serve(1, 1, 16'h0777, 16'h0);
        tick(); tick();
        check("t5_refetch_ok", slot0_ok, 1);

        // 6: reset in WAIT, stray data afterwards is ignored
        rc = req_count;
        push(T_REQ, 32'h080060);
        slot1_addr = 17'h30;
        slot1_cs   = 1'b1;
        wait_req();
        do_ack(1);
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_req_rst", sdram_req, 0);
        check("t6_ok0_rst", slot0_ok,  0);
        check("t6_ok1_rst", slot1_ok,  0);
        slot0_cs = 1'b0;
        slot1_cs = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        data_dst  = 1'b1;
        data_rdy  = 1'b1;
        data_read = 16'hDEAD;
        tick();
        data_dst  = 1'b0;
        data_rdy  = 1'b0;
        data_read = '0;
        tick();
        check("t6_req_idle",  sdram_req,  0);
        check("t6_dout1",     slot1_dout, 0);
        check("t6_dout0",     slot0_dout, 0);
        check("t6_req_count", req_count,  rc + 1);
        push(T_REQ, 32'h080060);
        push(T_OK1, 32'hBBBBAAAA);
        slot1_cs = 1'b1;
        serve(1, 2, 16'hAAAA, 16'hBBBB);
        tick(); tick();
        slot1_cs = 1'b0;

        repeat (5) tick();
        check("sb_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
